ysyx_22051086_wbu: RTL
======================

// Module: ysyx_22051086_wbu
// PURPOSE
//  Writeback stage of the RV64 core; sits directly upstream of the GPR file and drives its write port.
//  Accepts one retiring instruction per handshake from EXU. ALU results are written the next cycle.
//  Loads wait for the LSU response, then the data is aligned and sign/zero-extended and written.
//  Exposes the pending destination register for ID-stage hazard checks.
// PARAMETERS
//  XLEN    64  datapath / PC width
//  RADDR_W 5   register index width
// PORTS
//  clk           in   1     clock; all state updates on posedge
//  rst           in   1     synchronous active-high reset
//  in_valid      in   1     EXU presents an instruction
//  in_ready      out  1     WBU can accept
//  in_pc         in   XLEN  PC of the instruction
//  in_rd         in   5     destination register
//  in_rd_wen     in   1     instruction writes rd
//  in_is_load    in   1     result comes from LSU
//  in_ld_funct3  in   3     load type (LB/LH/LW/LD/LBU/LHU/LWU)
//  in_addr_lo    in   3     byte offset of the load address in its doubleword
//  in_alu_res    in   XLEN  non-load result
//  lsu_rvalid    in   1     load data valid (single-cycle pulse)
//  lsu_rdata     in   XLEN  raw aligned doubleword from memory
//  rf_wen        out  1     GPR write enable
//  rf_waddr      out  5     GPR write index
//  rf_wdata      out  XLEN  GPR write data
//  pend_valid    out  1     held instruction will write pend_rd
//  pend_rd       out  5     pending destination
//  commit_valid  out  1     instruction retires this cycle
//  commit_pc     out  XLEN  PC of the retiring instruction
//  instret       out  64    retired-instruction count
// BEHAVIOUR
//  - FSM states IDLE, WAIT_MEM, WRITE. in_ready = (state==IDLE || state==WRITE).
//  - Accept when in_valid && in_ready: latch all in_* fields. Go to WAIT_MEM if in_is_load, else to WRITE.
//  - WAIT_MEM: lsu_rvalid is sampled only in this state. On lsu_rvalid, latch the extended data and go to WRITE; otherwise hold indefinitely.
//  - WRITE (exactly one cycle): rf_wen = rd_wen && rd!=0; commit_valid = 1.
//    Next state: on a new accept, WRITE or WAIT_MEM as above; otherwise IDLE. Back-to-back ALU ops retire 1 per cycle.
//  - Latency: ALU op accepted at cycle N is written at N+1. Load with lsu_rvalid at cycle M is written at M+1.
//  - rf_waddr / rf_wdata / commit_pc are registered. Outside WRITE they hold their last values; rf_wen and commit_valid are 0.
//  - Load extension: shift lsu_rdata right by in_addr_lo*8 (zero-fill), then extend by funct3:
//    000 sext8, 001 sext16, 010 sext32, 011 pass64, 100 zext8, 101 zext16, 110 zext32, 111 pass64.
//    Misaligned offsets are not trapped; bytes beyond bit 63 read as zero.
//  - pend_valid = (WAIT_MEM||WRITE) && rd_wen && rd!=0; pend_rd = latched rd.
//  - rd==0 with rd_wen=1: still commits, never asserts rf_wen.
//  - lsu_rvalid in IDLE or WRITE is ignored (protocol error, no state change).
//  - rst has priority over all events, including mid-load:
//    state=IDLE; rf_wen=0, rf_waddr=0, rf_wdata=0, pend_valid=0, pend_rd=0, commit_valid=0, commit_pc=0, instret=0.
//    A load in flight at reset is dropped.
// CONFIGURATION
//  YSYX_22051086_COMMIT_TRACE_EN defined:
//    commit_valid/commit_pc are driven as above; instret increments by 1 on every WRITE cycle, wraps at 2^64.
//  Not defined:
//    commit_valid, commit_pc and instret are tied to 0 and their registers are not built. Writeback behaviour is unchanged.
// STRUCTURE
//  Package ysyx_22051086_pkg: wbu_state_t enum, LD_* funct3 localparams, XLEN constant.
//  Sub-module ysyx_22051086_ld_ext: combinational align + extend (lsu_rdata, addr_lo, funct3 -> XLEN).
// TESTING
//  1. ALU op, rd=5, res=0x1234: accept at c0 -> c1 rf_wen=1, waddr=5, wdata=0x1234, commit_valid=1; c2 idle.
//  2. LB addr_lo=3, rdata=0x0000_0000_8000_0000 (byte3=0x80): rvalid at cM -> cM+1 wdata=0xFFFF_FFFF_FFFF_FF80.
//     Same case as LBU -> wdata=0x80.
//  3. Load held 4 cycles without rvalid: in_ready=0, pend_valid=1, rf_wen=0 throughout.
//     A second in_valid is not accepted until the load's WRITE cycle.
//  4. Three back-to-back ALU ops rd=1,2,0: writes to x1 and x2 on consecutive cycles; x0 commits with rf_wen=0.
//     instret=3 with COMMIT_TRACE_EN defined.
//  5. rst asserted in WAIT_MEM, then rvalid one cycle after reset: no write; all outputs 0; state IDLE.
//  6. Build without COMMIT_TRACE_EN: rerun test 4 -> commit_valid=0 and instret=0 always; GPR writes identical.

Source files
------------

// File: rtl/ysyx_22051086_pkg.sv
// Shared types and constants for the ysyx_22051086 writeback stage.
package ysyx_22051086_pkg;

    localparam int XLEN    = 64;
    localparam int RADDR_W = 5;

    typedef enum logic [1:0] {
        WBU_IDLE     = 2'd0,
        WBU_WAIT_MEM = 2'd1,
        WBU_WRITE    = 2'd2
    } wbu_state_t;

    localparam logic [2:0] LD_LB  = 3'b000;
    localparam logic [2:0] LD_LH  = 3'b001;
    localparam logic [2:0] LD_LW  = 3'b010;
    localparam logic [2:0] LD_LD  = 3'b011;
    localparam logic [2:0] LD_LBU = 3'b100;
    localparam logic [2:0] LD_LHU = 3'b101;
    localparam logic [2:0] LD_LWU = 3'b110;

endpackage

// File: rtl/ysyx_22051086_ld_ext.sv
// Load data alignment: shift the raw doubleword down by the byte offset,
// then sign- or zero-extend according to the load funct3.
module ysyx_22051086_ld_ext
    import ysyx_22051086_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] rdata_i,
    input  logic [2:0]   addr_lo_i,
    input  logic [2:0]   funct3_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] sh;

    always_comb begin
        // Bytes shifted in from above bit 63 read as zero.
        sh     = rdata_i >> {addr_lo_i, 3'b000};
        data_o = sh;
        case (funct3_i)
            LD_LB:   data_o = {{(W-8){sh[7]}},   sh[7:0]};
            LD_LH:   data_o = {{(W-16){sh[15]}}, sh[15:0]};
            LD_LW:   data_o = {{(W-32){sh[31]}}, sh[31:0]};
            LD_LBU:  data_o = {{(W-8){1'b0}},    sh[7:0]};
            LD_LHU:  data_o = {{(W-16){1'b0}},   sh[15:0]};
            LD_LWU:  data_o = {{(W-32){1'b0}},   sh[31:0]};
            default: data_o = sh;
        endcase
    end

endmodule

// File: rtl/ysyx_22051086_wbu.sv
// Writeback stage: retires ALU results next cycle, loads after the LSU response.
// Commit trace (commit_valid/commit_pc/instret) is built only with YSYX_22051086_COMMIT_TRACE_EN.
module ysyx_22051086_wbu
    import ysyx_22051086_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_rd_wen,
    input  logic               in_is_load,
    input  logic [2:0]         in_ld_funct3,
    input  logic [2:0]         in_addr_lo,
    input  logic [XLEN-1:0]    in_alu_res,
    input  logic               lsu_rvalid,
    input  logic [XLEN-1:0]    lsu_rdata,
    output logic               rf_wen,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]    rf_wdata,
    output logic               pend_valid,
    output logic [RADDR_W-1:0] pend_rd,
    output logic               commit_valid,
    output logic [XLEN-1:0]    commit_pc,
    output logic [63:0]        instret
);

    wbu_state_t         state_q, state_d;
    logic [RADDR_W-1:0] rd_q;
    logic               rd_wen_q;
    logic [2:0]         funct3_q;
    logic [2:0]         addr_lo_q;
    logic [RADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]    wdata_q;
    logic [XLEN-1:0]    ld_data;
    logic               accept;
    logic               ld_done;
    logic               writes_rd;

    ysyx_22051086_ld_ext #(.W(XLEN)) u_ld_ext (
        .rdata_i   (lsu_rdata),
        .addr_lo_i (addr_lo_q),
        .funct3_i  (funct3_q),
        .data_o    (ld_data)
    );

    assign writes_rd = rd_wen_q && (rd_q != '0);

    always_comb begin
        state_d    = state_q;
        in_ready   = 1'b0;
        rf_wen     = 1'b0;
        pend_valid = 1'b0;
        accept     = 1'b0;
        ld_done    = 1'b0;
        case (state_q)
            WBU_IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (accept) state_d = in_is_load ? WBU_WAIT_MEM : WBU_WRITE;
            end
            WBU_WAIT_MEM: begin
                pend_valid = writes_rd;
                ld_done    = lsu_rvalid;
                if (ld_done) state_d = WBU_WRITE;
            end
            WBU_WRITE: begin
                in_ready   = 1'b1;
                rf_wen     = writes_rd;
                pend_valid = writes_rd;
                accept     = in_valid;
                if (accept) state_d = in_is_load ? WBU_WAIT_MEM : WBU_WRITE;
                else        state_d = WBU_IDLE;
            end
            default: state_d = WBU_IDLE;
        endcase
    end

    // rf_waddr/rf_wdata change only when an instruction enters WRITE, so they hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WBU_IDLE;
            rd_q      <= '0;
            rd_wen_q  <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            waddr_q   <= '0;
            wdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rd_q      <= in_rd;
                rd_wen_q  <= in_rd_wen;
                funct3_q  <= in_ld_funct3;
                addr_lo_q <= in_addr_lo;
                if (!in_is_load) begin
                    waddr_q <= in_rd;
                    wdata_q <= in_alu_res;
                end
            end else if (ld_done) begin
                waddr_q <= rd_q;
                wdata_q <= ld_data;
            end
        end
    end

    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign pend_rd  = rd_q;

`ifdef YSYX_22051086_COMMIT_TRACE_EN
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] commit_pc_q;
    logic [63:0]     instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= '0;
            commit_pc_q <= '0;
            instret_q   <= '0;
        end else begin
            if (accept) pc_q <= in_pc;
            if (accept && !in_is_load) commit_pc_q <= in_pc;
            else if (ld_done)          commit_pc_q <= pc_q;
            if (state_q == WBU_WRITE)  instret_q   <= instret_q + 64'd1;
        end
    end

    assign commit_valid = (state_q == WBU_WRITE);
    assign commit_pc    = commit_pc_q;
    assign instret      = instret_q;
`else
    logic unused_pc;
    assign unused_pc    = ^in_pc;
    assign commit_valid = 1'b0;
    assign commit_pc    = '0;
    assign instret      = '0;
`endif

endmodule
